// File: rtl/sonar_scheduler.sv
// sonar_scheduler: round-robin trigger/capture scheduler for HC-SR04 driver channels with watchdog, settle gap and result bank
module sonar_scheduler #(
  parameter int freq = 50_000_000,
  parameter int N_SENSORS = 4,
  parameter int GAP_CYCLES = freq / 16,
  parameter int TIMEOUT_CYCLES = 2 * freq,
  localparam int ID_W = $clog2(N_SENSORS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [N_SENSORS-1:0]   sensor_mask,
  output logic [N_SENSORS-1:0]   measure,
  input  logic [N_SENSORS-1:0]   ready,
  input  logic [8*N_SENSORS-1:0] distance_in,
  output logic                   busy,
  output logic [ID_W-1:0]        cur_id,
  output logic                   result_valid,
  output logic [ID_W-1:0]        result_id,
  output logic [7:0]             result_dist,
  output logic                   result_timeout,
  output logic [8*N_SENSORS-1:0] dist_all
);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, TRIGGER, ARM, WAIT_READY, CAPTURE, GAP} state_t;
  state_t state, state_nx;
  logic [ID_W-1:0] ptr, sel;
  logic [WD_W-1:0] wd;
  logic [GAP_W-1:0] gap;
  logic go, rdy, wd_done, timed_out;
  logic [7:0] cap_dist;
  assign go = enable && |sensor_mask;
  assign rdy = ready[ptr];
  assign wd_done = wd == '0;
  assign cap_dist = timed_out ? 8'hFF : distance_in[8*int'(ptr) +: 8];
  always_comb begin
    sel = ptr;
    for (int i = N_SENSORS; i >= 1; i--)
      if (sensor_mask[(int'(ptr) + i) % N_SENSORS]) sel = ID_W'((int'(ptr) + i) % N_SENSORS);
  end
  always_comb begin
    state_nx = state;
    timed_out = 1'b0;
    case (state)
      IDLE: state_nx = go ? TRIGGER : IDLE;
      TRIGGER: state_nx = ARM;
      ARM: begin
        timed_out = wd_done;
        state_nx = wd_done ? CAPTURE : rdy ? ARM : WAIT_READY;
      end
      WAIT_READY: begin
        timed_out = wd_done && !rdy;
        state_nx = (rdy || wd_done) ? CAPTURE : WAIT_READY;
      end
      CAPTURE: state_nx = GAP;
      GAP: state_nx = gap != '0 ? GAP : go ? TRIGGER : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ptr <= ID_W'(N_SENSORS - 1);
      wd <= '0;
      gap <= '0;
      measure <= '0;
      busy <= 1'b0;
      cur_id <= '0;
      result_valid <= 1'b0;
      result_id <= '0;
      result_dist <= '0;
      result_timeout <= 1'b0;
      dist_all <= '0;
    end else begin
      state <= state_nx;
      busy <= state_nx != IDLE;
      measure <= state_nx == TRIGGER ? N_SENSORS'(1) << sel : '0;
      result_valid <= state_nx == CAPTURE;
      if (state_nx == TRIGGER) begin
        ptr <= sel;
        cur_id <= sel;
        wd <= WD_W'(TIMEOUT_CYCLES);
      end else if ((state == ARM || state == WAIT_READY) && !wd_done) wd <= wd - 1'b1;
      if (state == CAPTURE) gap <= GAP_W'(GAP_CYCLES - 1);
      else if (gap != '0) gap <= gap - 1'b1;
      if (state_nx == CAPTURE) begin
        result_id <= ptr;
        result_dist <= cap_dist;
        result_timeout <= timed_out;
        dist_all[8*int'(ptr) +: 8] <= cap_dist;
      end
    end
endmodule

// File: doc/sonar_scheduler.md
# sonar_scheduler

Round-robin measurement scheduler for up to N HC-SR04 channels, each served by its own `sonar_driver` instance. It issues one-cycle `measure` pulses to one channel at a time and detects that channel's completion from its `ready` level. It enforces a settle gap between pings so echoes from one sensor cannot corrupt the next, and publishes each result as a tagged one-cycle event plus a per-channel distance register bank.

## Interface
- `freq`, 50_000_000, clock frequency in Hz.
- `N_SENSORS`, 4, number of driver channels (2..16).
- `GAP_CYCLES`, freq/16, idle cycles between end of one measurement and next trigger (~62.5 ms).
- `TIMEOUT_CYCLES`, 2*freq, watchdog from trigger to completion.
- ID_W = clog2(N_SENSORS), derived, not overridable.

Ports:
- `clk` in 1, system clock.
- `rst_n` in 1, asynchronous active-low reset.
- `enable` in 1, run continuous scheduling while high.
- `sensor_mask` in N_SENSORS, bit k=1 includes channel k in rotation.
- `measure` out N_SENSORS, one-hot one-cycle trigger to driver k.
- `ready` in N_SENSORS, level `ready` from driver k.
- `distance_in` in 8*N_SENSORS, driver k distance on bits [8k+7:8k].
- `busy` out 1, high in any state other than IDLE.
- `cur_id` out ID_W, channel currently or last scheduled.
- `result_valid` out 1, one-cycle pulse per completed or timed-out measurement.
- `result_id` out ID_W, channel of the result.
- `result_dist` out 8, distance (8'hFF on timeout).
- `result_timeout` out 1, qualifies `result_valid`: watchdog expired.
- `dist_all` out 8*N_SENSORS, last result per channel.

## Operation
- States: IDLE, TRIGGER, ARM, WAIT_READY, CAPTURE, GAP.
- IDLE: if `enable` and `|sensor_mask`, select next channel (below), load watchdog with TIMEOUT_CYCLES, go TRIGGER. Otherwise stay.
- Selection: search k = ptr+1, ptr+2, ... with wrap for the first k with `sensor_mask[k]`=1. After reset ptr = N_SENSORS-1, so channel 0 is searched first. A single enabled channel repeats. Mask is sampled only at selection.
- TRIGGER (1 cycle): `measure[k]`=1, go ARM.
- ARM: wait for `ready[k]`=0, since the driver holds `ready` high from the previous measurement until its trigger phase. Then go WAIT_READY.
- WAIT_READY: on `ready[k]`=1, go CAPTURE.
- Watchdog decrements in ARM and WAIT_READY. On reaching 0, go CAPTURE with the timeout flag set.
- CAPTURE (1 cycle):
  - Drive `result_valid`=1, `result_id`=k.
  - Drive `result_dist` = `distance_in[k]`, or 8'hFF on timeout. Set `result_timeout` accordingly.
  - Write the same value into the `dist_all` slice k.
  - Load gap counter with GAP_CYCLES, go GAP.
- GAP: decrement the gap counter. At 0: if `enable` and `|sensor_mask`, select the next channel and go TRIGGER; else go IDLE.
- `enable` falling or a mask bit clearing mid-measurement does not abort. The current measurement completes, is reported, and takes its full gap.
- Asynchronous reset at any time returns to IDLE with all outputs at reset values.

## Timing
- Reset values: `measure`=0, `busy`=0, `cur_id`=0, `result_valid`=0, `result_id`=0, `result_dist`=0, `result_timeout`=0, `dist_all`=0.
- All outputs are registered.
- IDLE exit at edge n: `measure[k]` high during cycle n+1 only. `busy` rises at n+1.
- `ready[k]` high sampled at edge m in WAIT_READY: `result_valid` high during cycle m+1. `dist_all` slice k updates at the same edge.
- Gap: the next `measure` pulse occurs exactly GAP_CYCLES+1 cycles after the `result_valid` cycle.
- Timeout: `result_valid` occurs TIMEOUT_CYCLES+2 cycles after the `measure` cycle if `ready[k]` never completes the low-then-high sequence.
- If `ready[k]` rises in the same cycle the watchdog reaches 0, the valid completion wins (`result_timeout`=0).
- At most one `measure` bit is high in any cycle. `measure` is never reissued before the gap expires.

## Test plan
Bench parameters: N_SENSORS=4, GAP_CYCLES=20, TIMEOUT_CYCLES=100. Driver models drop `ready` 3 cycles after `measure` and raise it 10 cycles later.
- Mask 4'b1011, `enable`=1 held: trigger order 0,1,3,0,1,3. Each `measure` is a single cycle. Trigger spacing is exactly 21 cycles after each `result_valid`.
- Channel 2 model returns distance 8'h5A, mask 4'b0100: `result_id`=2, `result_dist`=8'h5A, `dist_all`[23:16]=8'h5A, other slices 0.
- Channel 1 model never drops `ready`: `result_timeout`=1, `result_dist`=8'hFF, arriving 102 cycles after `measure`. Rotation continues to the next channel.
- `enable` dropped during WAIT_READY: the result is still reported, the gap elapses, then IDLE with `busy`=0 and no further `measure`.
- Mask changes from 4'b0011 to 4'b1000 mid-measurement of channel 0: channel 0 is reported, then the next trigger goes to channel 3.
- `rst_n` asserted during GAP: all outputs are 0 immediately. After release with `enable`=1 and mask 4'b1111, the first trigger is on channel 0.
